terasic_loopback_seq: RTL and testbench
=======================================

# terasic_loopback_seq

Sequencer for the GPIO loopback tester. It sits directly upstream of the loopback tester's Avalon-MM slave and drives it as a simple master. It runs one or more complete test passes, each of which resets the tester, lets it sweep all pairs and cases, and reads back the error vector. It accumulates the per-pair error mask and a failing-pass count for the control panel, which reads them through its own register wrapper.

## Interface
- PAIR_NUM, 32, loopback pair count; width of the error vector and master data bus.
- RESET_CYCLES, 2, cycles the tester reset bit is held low; minimum 1.
- RUN_CYCLES, 128, cycles allowed for one tester sweep; must be at least 4*PAIR_NUM when the tester runs bidirectional.
- ITER_W, 8, width of the iteration count and the fail counter.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled only in IDLE; launches a test.
- abort  in  1  synchronous; forces IDLE from any state.
- iterations  in  ITER_W  number of passes, sampled when start is accepted; 0 is treated as 1.
- m_cs, m_read, m_write  out  1 each  master strobes to the tester.
- m_writedata  out  PAIR_NUM  bit0 drives the tester reset; all other bits are always 0.
- m_readdata  in  PAIR_NUM  tester error vector; one cycle read latency.
- busy  out  1  high while a test is in progress.
- done  out  1  one-cycle pulse when all passes complete.
- pass  out  1  high when err_mask==0 at the last completion.
- err_mask  out  PAIR_NUM  OR of the error vectors from all passes of the current test.
- fail_cnt  out  ITER_W  number of passes that returned a nonzero vector.

## Operation
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- States: IDLE, ASSERT_RST, HOLD, RELEASE, RUN, READ, CAPTURE, DONE.
- IDLE:
  - start=1 → ASSERT_RST.
  - On this transition: err_mask and fail_cnt clear to 0; pass clears; the iteration counter loads max(iterations,1).
- ASSERT_RST: one cycle. m_cs=1, m_write=1, m_writedata=0. Next state is HOLD.
- HOLD: RESET_CYCLES cycles with all strobes 0. Next state is RELEASE.
- RELEASE: one cycle. m_cs=1, m_write=1, m_writedata[0]=1. Next state is RUN.
- RUN: RUN_CYCLES cycles with all strobes 0. Next state is READ.
- READ: one cycle. m_cs=1, m_read=1. Next state is CAPTURE.
- CAPTURE: one cycle with strobes 0; m_readdata is sampled at the end of this cycle.
  - err_mask <= err_mask | m_readdata.
  - fail_cnt increments if m_readdata != 0.
  - Iteration counter decrements.
  - If the counter was 1, next state is DONE; otherwise ASSERT_RST.
- DONE: one cycle. done=1, busy=0, pass <= (final err_mask==0). Next state is IDLE.
- busy=1 in every state from ASSERT_RST through CAPTURE; 0 in IDLE and DONE.
- m_read and m_write are never high in the same cycle. Strobes are registered outputs decoded from the state.
- start is ignored in every state except IDLE. Holding start high re-launches a test on the cycle after DONE.
- abort (highest priority, any non-IDLE state):
  - Next state is IDLE; busy drops next cycle.
  - No done pulse; pass unchanged.
  - err_mask and fail_cnt keep their partial values.
  - The tester reset bit is left in whatever state was last written.
- fail_cnt never exceeds iterations, so it cannot overflow.

## Timing
- Start accepted at edge 0: ASSERT_RST occupies cycle 1.
- One pass lasts 4+RESET_CYCLES+RUN_CYCLES cycles: 134 with the defaults.
- Single pass, defaults: done is high in cycle 135.
- N passes: done is high in cycle 1+N*(4+RESET_CYCLES+RUN_CYCLES).
- The tester registers s_readdata at the edge ending READ, so m_readdata is valid throughout CAPTURE.
- reset_n low mid-test: every output goes to 0 immediately, asynchronously; the sequencer restarts only on a new start.

## Test plan
- Clean loop model (tester returns 0), iterations=1, start pulse:
  - write 0 in cycle 1, write 1 in cycle 4, read in cycle 133;
  - done in cycle 135; pass=1, err_mask=0, fail_cnt=0.
- Tester returns 0x0000_0005 every pass, iterations=3:
  - three reset/read sequences; err_mask=0x5, fail_cnt=3, pass=0;
  - done exactly 1+3*134 cycles after start.
- Tester returns 0x1, then 0x0, then 0x8000_0000 across iterations=3:
  - err_mask=0x8000_0001, fail_cnt=2.
- iterations=0 → exactly one pass, fail_cnt at most 1.
- abort asserted during RUN of pass 2 of 4:
  - IDLE next cycle; no done; busy=0; err_mask keeps the pass-1 value.
  - start pulses during busy are ignored.
- reset_n pulsed low during HOLD:
  - all strobes and outputs are 0 in the same cycle;
  - a fresh start afterwards runs a full correct test.

Source files
------------

// File: rtl/terasic_loopback_seq.sv
// terasic_loopback_seq: drives the GPIO loopback tester through one or more
// reset/sweep/readback passes and accumulates the per-pair error mask and
// the number of failing passes.
module terasic_loopback_seq #(
  parameter int PAIR_NUM     = 32,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_CYCLES   = 128,
  parameter int ITER_W       = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ITER_W-1:0]   iterations,
  output logic                m_cs,
  output logic                m_read,
  output logic                m_write,
  output logic [PAIR_NUM-1:0] m_writedata,
  input  logic [PAIR_NUM-1:0] m_readdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [PAIR_NUM-1:0] err_mask,
  output logic [ITER_W-1:0]   fail_cnt
);

  // One shared down-counter times both HOLD and RUN, so it is sized for the longer.
  localparam int MAX_WAIT = (RUN_CYCLES > RESET_CYCLES) ? RUN_CYCLES : RESET_CYCLES;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_READ,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [PAIR_NUM-1:0] err_q, err_d;
  logic [ITER_W-1:0]   fail_q, fail_d;
  logic                pass_q, pass_d;
  logic                cs_q, cs_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                wd0_q, wd0_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and accumulator logic; abort overrides everything once a test is running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ASSERT_RST;
            err_d   = '0;
            fail_d  = '0;
            pass_d  = 1'b0;
            iter_d  = (iterations == '0) ? ITER_W'(1) : iterations;
          end
        end
        S_ASSERT_RST: begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(RESET_CYCLES - 1);
        end
        S_HOLD: begin
          if (cnt_q == '0) state_d = S_RELEASE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_RELEASE: begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(RUN_CYCLES - 1);
        end
        S_RUN: begin
          if (cnt_q == '0) state_d = S_READ;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_READ: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          err_d  = err_q | m_readdata;
          if (m_readdata != '0) fail_d = fail_q + ITER_W'(1);
          iter_d = iter_q - ITER_W'(1);
          state_d = (iter_q <= ITER_W'(1)) ? S_DONE : S_ASSERT_RST;
        end
        S_DONE: begin
          state_d = S_IDLE;
          pass_d  = (err_q == '0);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes and status are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    cs_d   = (state_d == S_ASSERT_RST) || (state_d == S_RELEASE) || (state_d == S_READ);
    wr_d   = (state_d == S_ASSERT_RST) || (state_d == S_RELEASE);
    rd_d   = (state_d == S_READ);
    wd0_d  = (state_d == S_RELEASE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wd0_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wd0_q   <= wd0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign m_cs        = cs_q;
  assign m_read      = rd_q;
  assign m_write     = wr_q;
  assign m_writedata = PAIR_NUM'(wd0_q);
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_mask    = err_q;
  assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_terasic_loopback_seq.sv
// Testbench for terasic_loopback_seq: a queue-driven stand-in for the loopback
// tester supplies one error vector per read, and each test is predicted from
// the pass count and the queued vectors alone.
`timescale 1ns/1ps
module tb_terasic_loopback_seq;

  localparam int PASS_LEN = 4 + 2 + 128;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  iterations;
  logic        m_cs;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] err_mask;
  logic [7:0]  fail_cnt;

  int totalCount = 0;
  int badCount   = 0;

  logic [31:0] vecQ[$];

  terasic_loopback_seq #(
    .PAIR_NUM(32), .RESET_CYCLES(2), .RUN_CYCLES(128), .ITER_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .iterations(iterations), .m_cs(m_cs), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .busy(busy),
    .done(done), .pass(pass), .err_mask(err_mask), .fail_cnt(fail_cnt)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tester stand-in: a read registers the next queued vector, so it is valid in the following cycle.
  always @(posedge clk) begin
    if (m_cs && m_read) begin
      if (vecQ.size() > 0) m_readdata <= vecQ.pop_front();
      else                 m_readdata <= '0;
    end
  end

  // Safety net so the run always ends even if something wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalCount, badCount);
    $fatal(1, "[TB] watchdog");
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one complete test using the vectors already queued and checks timing, bus traffic and results.
  task automatic applyStimulus(input logic [7:0] iterIn, input bit checkTiming);
    int n, rel, doneAt, nWr, nRd, wr0At, wr1At, rdAt, expFail;
    bit overlap, busyAt1;
    logic [31:0] expErr;
    n = (iterIn == 0) ? 1 : int'(iterIn);
    expErr = '0;
    expFail = 0;
    for (int i = 0; i < n; i++) begin
      expErr |= vecQ[i];
      if (vecQ[i] != 0) expFail++;
    end
    doneAt = -1; nWr = 0; nRd = 0; wr0At = -1; wr1At = -1; rdAt = -1;
    overlap = 0; busyAt1 = 0;
    @(negedge clk);
    start = 1'b1;
    iterations = iterIn;
    @(negedge clk);
    start = 1'b0;
    rel = 1;
    busyAt1 = busy;
    while (rel <= 1 + n * PASS_LEN + 5) begin
      if (m_read && m_write) overlap = 1;
      if (m_cs && m_write) begin
        nWr++;
        if (m_writedata == 32'd0 && wr0At < 0) wr0At = rel;
        if (m_writedata == 32'd1 && wr1At < 0) wr1At = rel;
      end
      if (m_cs && m_read) begin
        nRd++;
        if (rdAt < 0) rdAt = rel;
      end
      if (done) begin
        doneAt = rel;
        break;
      end
      @(negedge clk);
      rel++;
    end
    checkOutput("busyAfterStart", busyAt1, 1);
    checkOutput("doneCycle", doneAt, 1 + n * PASS_LEN);
    checkOutput("busyInDone", busy, 0);
    checkOutput("errMask", err_mask, expErr);
    checkOutput("failCnt", fail_cnt, expFail);
    checkOutput("writeCount", nWr, 2 * n);
    checkOutput("readCount", nRd, n);
    checkOutput("rdWrOverlap", overlap, 0);
    if (checkTiming) begin
      checkOutput("write0Cycle", wr0At, 1);
      checkOutput("write1Cycle", wr1At, 4);
      checkOutput("readCycle", rdAt, 133);
    end
    @(negedge clk);
    checkOutput("passFlag", pass, (expErr == 0));
    checkOutput("idleBusy", busy, 0);
  endtask

  // Launches a 4-pass test, pokes start while busy, then aborts in the second pass's sweep.
  task automatic applyAbort();
    int rel, nWr, nRd;
    bit sawDone, sawBusy;
    vecQ.delete();
    vecQ.push_back(32'h0000_0030);
    vecQ.push_back(32'h0000_00ff);
    vecQ.push_back(32'h0000_00ff);
    vecQ.push_back(32'h0000_00ff);
    nWr = 0; nRd = 0; sawDone = 0; sawBusy = 0;
    @(negedge clk);
    start = 1'b1;
    iterations = 8'd4;
    @(negedge clk);
    start = 1'b0;
    rel = 1;
    while (rel <= 150) begin
      if (m_cs && m_write) nWr++;
      if (m_cs && m_read) nRd++;
      if (rel == 20) start = 1'b1;
      if (rel == 21) start = 1'b0;
      if (rel == 150) abort = 1'b1;
      @(negedge clk);
      rel++;
    end
    abort = 1'b0;
    checkOutput("abortWrites", nWr, 4);
    checkOutput("abortReads", nRd, 1);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortStrobes", {m_cs, m_read, m_write}, 0);
    checkOutput("abortErrMask", err_mask, 32'h0000_0030);
    checkOutput("abortFailCnt", fail_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      if (done) sawDone = 1;
      if (busy) sawBusy = 1;
      @(negedge clk);
    end
    checkOutput("abortNoDone", sawDone, 0);
    checkOutput("abortStaysIdle", sawBusy, 0);
    checkOutput("abortPass", pass, 0);
    checkOutput("abortErrKept", err_mask, 32'h0000_0030);
  endtask

  // Pulls reset low during HOLD and checks everything drops at once and stays idle.
  task automatic applyResetMidTest();
    bit sawBusy;
    vecQ.delete();
    vecQ.push_back(32'h1);
    vecQ.push_back(32'h2);
    sawBusy = 0;
    @(negedge clk);
    start = 1'b1;
    iterations = 8'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("busyBeforeReset", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rstCtrlOuts", {busy, done, pass, m_cs, m_read, m_write}, 0);
    checkOutput("rstWriteData", m_writedata, 0);
    checkOutput("rstErrFail", {err_mask, fail_cnt}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) sawBusy = 1;
    end
    checkOutput("noRestartAfterRst", sawBusy, 0);
  endtask

  // Sequences all scenarios and prints the summary.
  initial begin
    logic [7:0] itr;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    iterations = 8'd0;
    #1;
    checkOutput("resetOuts", {busy, done, pass, m_cs, m_read, m_write}, 0);
    checkOutput("resetData", {err_mask, fail_cnt, m_writedata}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] clean single pass");
    vecQ.delete();
    vecQ.push_back(32'h0);
    applyStimulus(8'd1, 1);

    $display("[TB] constant 0x5 over three passes");
    vecQ.delete();
    repeat (3) vecQ.push_back(32'h5);
    applyStimulus(8'd3, 0);

    $display("[TB] mixed vectors over three passes");
    vecQ.delete();
    vecQ.push_back(32'h1);
    vecQ.push_back(32'h0);
    vecQ.push_back(32'h8000_0000);
    applyStimulus(8'd3, 0);

    $display("[TB] zero iterations treated as one");
    vecQ.delete();
    vecQ.push_back(32'h40);
    vecQ.push_back(32'h80);
    applyStimulus(8'd0, 1);

    $display("[TB] randomized tests");
    for (int t = 0; t < 4; t++) begin
      vecQ.delete();
      itr = 8'($urandom_range(1, 4));
      for (int i = 0; i < int'(itr); i++)
        vecQ.push_back(($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom));
      applyStimulus(itr, 0);
    end

    $display("[TB] abort during second pass");
    applyAbort();

    $display("[TB] reset during HOLD then fresh test");
    applyResetMidTest();
    vecQ.delete();
    vecQ.push_back(32'($urandom) | 32'h1);
    vecQ.push_back(32'h0);
    applyStimulus(8'd2, 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
